prefetch_queue: RTL
===================

// Module: prefetch_queue
// PURPOSE
// - Parametrised instruction prefetch unit for the bus interface: forms physical fetch address (CS<<4)+fetch_ip.
// - Runs req/ack bus read cycles and buffers fetched bytes in a DEPTH-byte ring.
// - Presents a WIN_BYTES-wide instruction window to the execution side and retires bytes on a consume count.
// - Flushes on IP reload (jump/call); supersedes the fixed 32-bit byte queue.
// PARAMETERS
// - BUS_BYTES  1   bytes per bus read; legal values 1 or 2
// - DEPTH      6   queue capacity in bytes; >= WIN_BYTES, >= 2*BUS_BYTES, need not be a power of 2
// - WIN_BYTES  4   bytes presented in instr_window
// - ADDR_W     20  physical address width
// PORTS
// - clk           in   1                       system clock, rising edge
// - rst           in   1                       asynchronous, active-low reset
// - cs            in   16                      code segment value, sampled when a request is issued
// - ip_load       in   1                       load ip_new, flush queue
// - ip_new        in   16                      new instruction pointer
// - bus_req       out  1                       read request
// - bus_addr      out  ADDR_W                  read address
// - bus_ack       in   1                       read done, bus_rdata valid
// - bus_rdata     in   8*BUS_BYTES             read data, little-endian
// - consume_en    in   1                       retire bytes this cycle
// - consume       in   $clog2(WIN_BYTES+1)     number of bytes to retire
// - instr_window  out  8*WIN_BYTES             byte 0 (LSB) = oldest queued byte
// - valid_bytes   out  $clog2(DEPTH+1)         queued byte count
// - exec_ip       out  16                      IP of window byte 0
// - fetch_ip      out  16                      IP of next byte to fetch
// BEHAVIOUR
// - Reset: bus_req=0, bus_addr=0, instr_window=0, valid_bytes=0, exec_ip=0, fetch_ip=0; FSM in IDLE.
// - FSM states: IDLE, REQ, DISCARD.
//   - IDLE->REQ when free space (DEPTH-valid_bytes) >= BUS_BYTES and ip_load=0.
//     On that edge: bus_addr <= ({cs,4'h0}+fetch_ip) mod 2^ADDR_W; bus_req <= 1.
//   - In REQ: bus_req and bus_addr held stable until bus_ack.
//     On ack: push bytes, fetch_ip advances, bus_req <= 0, state -> IDLE (no back-to-back req; 1 idle cycle).
//   - ip_load while REQ: state -> DISCARD; bus_req held until ack; data on that ack dropped; then -> IDLE.
//   - ip_load in the same cycle as ack in REQ: data dropped, state -> IDLE.
// - Push with BUS_BYTES=2:
//   - fetch_ip even: push both bytes; fetch_ip += 2.
//   - fetch_ip odd: bus_addr is the odd address; push only bus_rdata[15:8]; fetch_ip += 1.
// - fetch_ip and exec_ip wrap mod 2^16. Address add wraps mod 2^ADDR_W (FFFF:0010 -> 0x00000).
// - Consume: n = min(consume, valid_bytes); clamping is silent. exec_ip += n; read pointer += n mod DEPTH.
// - Same-cycle push and consume are both applied: valid_bytes' = valid_bytes - n + pushed.
//   Free-space check for issuing uses registered valid_bytes.
// - ip_load priority: overrides push and consume in that cycle.
//   Next cycle: valid_bytes=0, exec_ip=fetch_ip=ip_new.
// - instr_window is combinational from the ring. Bytes at index >= valid_bytes read as 8'h00.
//   A pushed byte is visible the cycle after ack.
// - Full: no request while free < BUS_BYTES; an outstanding request always has room reserved.
// - Reset mid-request: bus_req drops immediately (async); the bus agent must tolerate an abandoned cycle.
// STRUCTURE
// - Shared include prefetch_defs.vh: FSM state encodings (IDLE=2'd0, REQ=2'd1, DISCARD=2'd2), bus width constants.
// - Sub-module byte_ring (params DEPTH, PUSH_MAX=BUS_BYTES, WIN=WIN_BYTES):
//   - multi-byte push/pop, modulo-DEPTH pointers, count, zero-masked window.
// - prefetch_queue itself holds the FSM, IP registers, address adder.
// TESTING
// - Reset, cs=16'h1000, ip_new=16'h0100 loaded, ack 1 cycle after each req
//   -> first bus_addr=20'h10100; fetches stop at valid_bytes=6 (defaults).
// - Push 8'h11..8'h16, consume_en with consume=3
//   -> window=32'h00161514 then refill; exec_ip=16'h0103.
// - BUS_BYTES=2, ip_new=16'h0101, bus_rdata=16'hAABB
//   -> only 8'hAA queued; fetch_ip=16'h0102; next addr even.
// - ip_load while bus_req=1 and ack delayed 3 cycles
//   -> req held, acked data discarded, valid_bytes=0, next req at new address.
// - cs=16'hFFFF, fetch_ip=16'h0010 -> bus_addr=20'h00000. fetch_ip=16'hFFFF then +1 -> 16'h0000.
// - consume=4 with valid_bytes=2, plus simultaneous ack -> valid_bytes=1 next cycle.
// - Async rst during REQ -> all outputs zero without a clock edge.

Source files
------------

// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
// - Bus FSM state encodings.
// - Modulo add helper used for ring pointer arithmetic.
package prefetch_queue_pkg;

  localparam int unsigned StateW = 2;

  localparam logic [StateW-1:0] StIdle    = 2'd0;
  localparam logic [StateW-1:0] StReq     = 2'd1;
  localparam logic [StateW-1:0] StDiscard = 2'd2;

  // (base + off) mod depth, valid while base < depth and off <= depth.
  function automatic int unsigned wrap_add(int unsigned base, int unsigned off,
                                           int unsigned depth);
    int unsigned s;
    s = base + off;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage

// File: rtl/prefetch_queue_byte_ring.sv
// Byte ring buffer with multi-byte push and pop and a zero-masked read window.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   flush           empty the ring (overrides push and pop)
//   push_cnt        number of bytes to push from push_data (byte 0 first)
//   push_data       push bytes, little-endian
//   pop_req         requested pop count; clamped to the current count
//   pop_cnt         pop count actually applied this cycle
//   window          WIN oldest bytes, byte 0 in the LSBs; empty slots read 0
//   count           bytes currently held
module prefetch_queue_byte_ring
  import prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 6,
  parameter int unsigned PUSH_MAX = 1,
  parameter int unsigned WIN      = 4,
  localparam int unsigned PtrW    = $clog2(DEPTH),
  localparam int unsigned CntW    = $clog2(DEPTH + 1),
  localparam int unsigned PushW   = $clog2(PUSH_MAX + 1),
  localparam int unsigned PopW    = $clog2(WIN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [PushW-1:0]      push_cnt,
  input  logic [8*PUSH_MAX-1:0] push_data,
  input  logic [PopW-1:0]       pop_req,
  output logic [PopW-1:0]       pop_cnt,
  output logic [8*WIN-1:0]      window,
  output logic [CntW-1:0]       count
);

  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [PtrW-1:0] rd_q, rd_d;
  logic [PtrW-1:0] wr_q, wr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  int unsigned     n_pop;

  always_comb begin
    n_pop = 32'(pop_req);
    if (n_pop > 32'(cnt_q)) n_pop = 32'(cnt_q);
    pop_cnt = PopW'(n_pop);

    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      for (int unsigned i = 0; i < PUSH_MAX; i++) begin
        if (i < 32'(push_cnt)) begin
          mem_d[PtrW'(wrap_add(32'(wr_q), i, DEPTH))] = push_data[8*i +: 8];
        end
      end
      wr_d  = PtrW'(wrap_add(32'(wr_q), 32'(push_cnt), DEPTH));
      rd_d  = PtrW'(wrap_add(32'(rd_q), n_pop, DEPTH));
      // Push and pop in the same cycle both apply.
      cnt_d = CntW'(32'(cnt_q) - n_pop + 32'(push_cnt));
    end
  end

  always_comb begin
    window = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      if (i < 32'(cnt_q)) begin
        window[8*i +: 8] = mem_q[PtrW'(wrap_add(32'(rd_q), i, DEPTH))];
      end
    end
  end

  assign count = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches code bytes at (cs<<4)+fetch_ip over a
// req/ack bus, buffers them in a byte ring and presents an instruction window.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   cs              code segment, sampled when a request is issued
//   ip_load/ip_new  reload both IPs and flush the queue
//   bus_req/addr    read request, held stable until bus_ack
//   bus_ack/rdata   read completion and data, little-endian
//   consume_en/cnt  retire bytes from the front of the window
//   instr_window    oldest bytes, byte 0 in the LSBs; empty slots read 0
//   valid_bytes     queued byte count
//   exec_ip         IP of window byte 0
//   fetch_ip        IP of the next byte to fetch
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 1,
  parameter int unsigned DEPTH     = 6,
  parameter int unsigned WIN_BYTES = 4,
  parameter int unsigned ADDR_W    = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [15:0]                    cs,
  input  logic                           ip_load,
  input  logic [15:0]                    ip_new,
  output logic                           bus_req,
  output logic [ADDR_W-1:0]              bus_addr,
  input  logic                           bus_ack,
  input  logic [8*BUS_BYTES-1:0]         bus_rdata,
  input  logic                           consume_en,
  input  logic [$clog2(WIN_BYTES+1)-1:0] consume,
  output logic [8*WIN_BYTES-1:0]         instr_window,
  output logic [$clog2(DEPTH+1)-1:0]     valid_bytes,
  output logic [15:0]                    exec_ip,
  output logic [15:0]                    fetch_ip
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned PopW  = $clog2(WIN_BYTES + 1);
  localparam int unsigned PushW = $clog2(BUS_BYTES + 1);

  logic [StateW-1:0]      state_q, state_d;
  logic                   bus_req_q, bus_req_d;
  logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
  logic [15:0]            exec_ip_q, exec_ip_d;
  logic [15:0]            fetch_ip_q, fetch_ip_d;

  logic [PushW-1:0]       push_cnt;
  logic [8*BUS_BYTES-1:0] push_data;
  logic [PopW-1:0]        pop_req;
  logic [PopW-1:0]        pop_cnt;
  logic [CntW-1:0]        ring_cnt;
  logic [ADDR_W-1:0]      fetch_addr;
  logic                   odd_fetch;
  logic                   free_ok;

  assign fetch_addr = ADDR_W'({cs, 4'h0}) + ADDR_W'(fetch_ip_q);
  // A wide bus at an odd IP only delivers the upper byte as useful data.
  assign odd_fetch  = (BUS_BYTES == 2) && fetch_ip_q[0];
  // Registered count only: the single outstanding request always has room.
  assign free_ok    = (DEPTH - 32'(ring_cnt)) >= BUS_BYTES;

  always_comb begin
    state_d    = state_q;
    bus_req_d  = bus_req_q;
    bus_addr_d = bus_addr_q;
    fetch_ip_d = fetch_ip_q;
    push_cnt   = '0;
    push_data  = odd_fetch ? (bus_rdata >> 8) : bus_rdata;
    pop_req    = consume_en ? consume : '0;

    case (state_q)
      StIdle: begin
        if (!ip_load && free_ok) begin
          state_d    = StReq;
          bus_req_d  = 1'b1;
          bus_addr_d = fetch_addr;
        end
      end
      StReq: begin
        if (bus_ack) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          if (!ip_load) begin
            push_cnt   = odd_fetch ? PushW'(1) : PushW'(BUS_BYTES);
            fetch_ip_d = fetch_ip_q + (odd_fetch ? 16'd1 : 16'(BUS_BYTES));
          end
        end else if (ip_load) begin
          // Bus cycle cannot be cancelled; finish it and drop its data.
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (bus_ack) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = StIdle;
        bus_req_d = 1'b0;
      end
    endcase

    exec_ip_d = exec_ip_q + 16'(pop_cnt);
    if (ip_load) begin
      exec_ip_d  = ip_new;
      fetch_ip_d = ip_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
      exec_ip_q  <= '0;
      fetch_ip_q <= '0;
    end else begin
      state_q    <= state_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      exec_ip_q  <= exec_ip_d;
      fetch_ip_q <= fetch_ip_d;
    end
  end

  prefetch_queue_byte_ring #(
    .DEPTH    (DEPTH),
    .PUSH_MAX (BUS_BYTES),
    .WIN      (WIN_BYTES)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .flush     (ip_load),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop_req   (pop_req),
    .pop_cnt   (pop_cnt),
    .window    (instr_window),
    .count     (ring_cnt)
  );

  assign bus_req     = bus_req_q;
  assign bus_addr    = bus_addr_q;
  assign valid_bytes = ring_cnt;
  assign exec_ip     = exec_ip_q;
  assign fetch_ip    = fetch_ip_q;

endmodule
